// File: rtl/traceback_unit_pkg.sv
// Shared encodings for the traceback unit: op codes, V-matrix direction codes,
// matrix and FSM states, and bit positions inside a direction-memory word.
package traceback_unit_pkg;

    typedef enum logic [1:0] {
        OP_M = 2'd0,
        OP_I = 2'd1,
        OP_D = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        V_START  = 2'd0,
        V_DIAG   = 2'd1,
        V_FROM_D = 2'd2,
        V_FROM_I = 2'd3
    } v_dir_e;

    typedef enum logic [1:0] {
        MAT_V,
        MAT_I,
        MAT_D
    } mat_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECIDE,
        S_EMIT,
        S_DONE
    } state_e;

    // Memory word layout: {d_direct, i_direct, v_direct[1:0]}
    localparam int MW_W     = 4;
    localparam int MW_D_BIT = 3;
    localparam int MW_I_BIT = 2;
    localparam int MW_V_LSB = 0;

endpackage

// File: rtl/traceback_unit_rle.sv
// Run-length merger (module tb_rle): folds consecutive identical ops into one
// output op carrying the run count. Only built when TB_RUNLENGTH_EN is defined.
`ifdef TB_RUNLENGTH_EN
module tb_rle
    import traceback_unit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  op_e              i_op,
    input  logic             i_last,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0]       o_op,
    output logic [CNT_W-1:0] o_len
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    op_e              run_op_q, run_op_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            run_op_q  <= OP_M;
            run_cnt_q <= '0;
        end else begin
            run_op_q  <= run_op_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    // A held run is pushed out when the incoming op cannot join it; the
    // incoming op is only absorbed once that flush has been accepted.
    always_comb begin
        flush     = i_valid && (run_cnt_q != '0) &&
                    (i_last || (i_op != run_op_q) || (run_cnt_q == CNT_MAX));
        o_valid   = flush;
        o_op      = flush ? run_op_q : OP_M;
        o_len     = flush ? run_cnt_q : '0;
        o_ready   = !flush || i_ready;
        run_op_d  = run_op_q;
        run_cnt_d = run_cnt_q;
        if (i_valid && o_ready) begin
            if (i_last) begin
                run_cnt_d = '0;
            end else begin
                run_op_d  = i_op;
                run_cnt_d = flush ? CNT_W'(1) : run_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/traceback_unit.sv
// Affine-gap alignment traceback: walks the V/I/D direction memory from an end
// cell back to the start, emitting ops end-to-start. TB_RUNLENGTH_EN merges runs.
module traceback_unit
    import traceback_unit_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_row,
    input  logic [ADDR_W-1:0]   i_col,
    output logic                o_mem_rd,
    output logic [2*ADDR_W-1:0] o_mem_addr,
    input  logic [MW_W-1:0]     i_mem_data,
    output logic                o_op_valid,
    input  logic                i_op_ready,
    output logic [1:0]          o_op,
    output logic [CNT_W-1:0]    o_op_len,
    output logic                o_busy,
    output logic                o_done
);

    state_e            state_q, state_d;
    mat_e              mat_q, mat_d;
    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
    op_e               op_q, op_d;
    logic              term_q, term_d;
    logic [MW_W-1:0]   word_q, word_d;
    logic              snk_valid, snk_ready;
    v_dir_e            v_dir;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            mat_q   <= MAT_V;
            row_q   <= '0;
            col_q   <= '0;
            op_q    <= OP_M;
            term_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            row_q   <= row_d;
            col_q   <= col_d;
            op_q    <= op_d;
            term_q  <= term_d;
            word_q  <= word_d;
        end
    end

    assign v_dir = v_dir_e'(word_q[MW_V_LSB +: 2]);

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        mat_d   = mat_q;
        row_d   = row_q;
        col_d   = col_q;
        op_d    = op_q;
        term_d  = term_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: if (i_start) begin
                row_d   = i_row;
                col_d   = i_col;
                mat_d   = MAT_V;
                term_d  = 1'b0;
                state_d = (i_row == '0 && i_col == '0) ? S_DONE : S_FETCH;
            end
            // Matrix edges need no memory: only one move remains possible.
            S_FETCH: begin
                if (row_q == '0 && col_q == '0) begin
                    term_d  = 1'b1;
                    state_d = S_EMIT;
                end else if (row_q == '0) begin
                    op_d    = OP_I;
                    col_d   = col_q - ADDR_W'(1);
                    state_d = S_EMIT;
                end else if (col_q == '0) begin
                    op_d    = OP_D;
                    row_d   = row_q - ADDR_W'(1);
                    state_d = S_EMIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                word_d  = i_mem_data;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                case (mat_q)
                    MAT_V: begin
                        case (v_dir)
                            V_DIAG: begin
                                op_d    = OP_M;
                                row_d   = row_q - ADDR_W'(1);
                                col_d   = col_q - ADDR_W'(1);
                                state_d = S_EMIT;
                            end
                            V_FROM_D: mat_d = MAT_D;
                            V_FROM_I: mat_d = MAT_I;
                            default: begin
                                term_d  = 1'b1;
                                state_d = S_EMIT;
                            end
                        endcase
                    end
                    MAT_D: begin
                        op_d    = OP_D;
                        row_d   = row_q - ADDR_W'(1);
                        mat_d   = word_q[MW_D_BIT] ? MAT_V : MAT_D;
                        state_d = S_EMIT;
                    end
                    MAT_I: begin
                        op_d    = OP_I;
                        col_d   = col_q - ADDR_W'(1);
                        mat_d   = word_q[MW_I_BIT] ? MAT_V : MAT_I;
                        state_d = S_EMIT;
                    end
                    default: mat_d = MAT_V;
                endcase
            end
            S_EMIT: if (snk_ready) state_d = term_q ? S_DONE : S_FETCH;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_rd   = (state_q == S_FETCH) && (row_q != '0) && (col_q != '0);
        o_mem_addr = o_mem_rd ? {row_q, col_q} : '0;
        o_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        o_done     = (state_q == S_DONE);
        snk_valid  = (state_q == S_EMIT);
    end

`ifdef TB_RUNLENGTH_EN
    tb_rle #(.CNT_W(CNT_W)) u_rle (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (snk_valid),
        .i_op    (op_q),
        .i_last  (term_q),
        .o_ready (snk_ready),
        .o_valid (o_op_valid),
        .i_ready (i_op_ready),
        .o_op    (o_op),
        .o_len   (o_op_len)
    );
`else
    // The termination pass through EMIT carries no op and completes at once.
    always_comb begin
        o_op_valid = snk_valid && !term_q;
        o_op       = o_op_valid ? op_q : OP_M;
        o_op_len   = o_op_valid ? CNT_W'(1) : '0;
        snk_ready  = term_q || i_op_ready;
    end
`endif

endmodule

// File: tb/tb_traceback_unit.sv
// Scoreboard bench for traceback_unit: a direction-memory model feeds the DUT,
// expected op streams are queued per traceback and popped on each handshake.
module tb_traceback_unit;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [1:0] op;
        logic [7:0] len;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_start = 1'b0;
    logic [ADDR_W-1:0]   i_row = '0;
    logic [ADDR_W-1:0]   i_col = '0;
    logic                o_mem_rd;
    logic [2*ADDR_W-1:0] o_mem_addr;
    logic [3:0]          mem_q = 4'd0;
    logic                o_op_valid;
    logic                i_op_ready = 1'b1;
    logic [1:0]          o_op;
    logic [CNT_W-1:0]    o_op_len;
    logic                o_busy;
    logic                o_done;

    logic [3:0] mem [int];
    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         rd_count = 0;
    int         done_count = 0;
    int         ready_mode = 0;
    bit         stalled_prev = 1'b0;
    logic [1:0] held_op;
    logic [7:0] held_len;

    traceback_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (i_start),
        .i_row      (i_row),
        .i_col      (i_col),
        .o_mem_rd   (o_mem_rd),
        .o_mem_addr (o_mem_addr),
        .i_mem_data (mem_q),
        .o_op_valid (o_op_valid),
        .i_op_ready (i_op_ready),
        .o_op       (o_op),
        .o_op_len   (o_op_len),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int key(input int r, input int c);
        return (r << ADDR_W) | c;
    endfunction

    function automatic logic [1:0] code(input byte ch);
        return (ch == "I") ? 2'd1 : (ch == "D") ? 2'd2 : 2'd0;
    endfunction

    // Synchronous direction memory: word valid the cycle after the strobe.
    always @(posedge clk)
        if (o_mem_rd) mem_q <= mem.exists(int'(o_mem_addr)) ? mem[int'(o_mem_addr)] : 4'd0;

    always @(negedge clk) if (o_mem_rd) rd_count++;

    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0: i_op_ready = 1'b1;
            1: i_op_ready = ~i_op_ready;
            default: i_op_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("hold_valid", o_op_valid, 1);
                check("hold_op", o_op, held_op);
                check("hold_len", o_op_len, held_len);
            end
            if (o_op_valid && i_op_ready) begin
                stalled_prev = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_op", o_op_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("op", o_op, e.op);
                    check("op_len", o_op_len, e.len);
                end
            end else if (o_op_valid) begin
                stalled_prev = 1'b1;
                held_op      = o_op;
                held_len     = o_op_len;
            end else begin
                stalled_prev = 1'b0;
            end
            if (o_done) done_count++;
        end
    end

    task automatic expect_ops(input string s);
`ifdef TB_RUNLENGTH_EN
        logic [1:0] cur;
        int run;
        cur = 2'd0;
        run = 0;
`endif
        for (int i = 0; i < s.len(); i++) begin
`ifdef TB_RUNLENGTH_EN
            if (run != 0 && (code(s[i]) != cur || run == 255)) begin
                sb.push_back('{cur, 8'(run)});
                run = 0;
            end
            cur = code(s[i]);
            run++;
`else
            sb.push_back('{code(s[i]), 8'd1});
`endif
        end
`ifdef TB_RUNLENGTH_EN
        if (run != 0) sb.push_back('{cur, 8'(run)});
`endif
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_flags"}, {o_busy, o_mem_rd, o_op_valid, o_done}, 0);
        check({tag, "_op"}, o_op, 0);
        check({tag, "_len"}, o_op_len, 0);
        check({tag, "_addr"}, o_mem_addr, 0);
    endtask

    task automatic run_tb(input string tag, input int r, input int c, input string ops,
                          input int exp_reads, input bit inject_busy, input bit inject_done);
        int cyc;
        int rd0;
        expect_ops(ops);
        rd0 = rd_count;
        @(posedge clk); #1;
        i_row   = ADDR_W'(r);
        i_col   = ADDR_W'(c);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check({tag, "_busy"}, o_busy, 32'(r != 0 || c != 0));
        cyc = 0;
        while (!o_done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (inject_busy && cyc == 2) begin
                check({tag, "_busy_at_inject"}, o_busy, 1);
                i_row   = '0;
                i_col   = '0;
                i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        check({tag, "_done"}, o_done, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_reads"}, rd_count - rd0, exp_reads);
        if (inject_done) begin
            i_row   = 10'd1;
            i_col   = 10'd1;
            i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
            check({tag, "_start_at_done"}, {o_busy, o_done}, 0);
        end
        sb.delete();
    endtask

    initial begin
        int cyc;
        int dc0;
        #12;
        check_idle_outs("rst_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outs("rst_idle");

        mem.delete();
        mem[key(3, 3)] = 4'b0001;
        mem[key(2, 2)] = 4'b0001;
        mem[key(1, 1)] = 4'b0001;
        run_tb("diag33", 3, 3, "MMM", 3, 0, 0);

        mem.delete();
        mem[key(2, 4)] = 4'b0011;
        mem[key(2, 3)] = 4'b0100;
        mem[key(2, 2)] = 4'b0001;
        mem[key(1, 1)] = 4'b0001;
        run_tb("ins24", 2, 4, "IIMM", 4, 0, 0);

        mem.delete();
        mem[key(3, 1)] = 4'b0010;
        mem[key(2, 1)] = 4'b1000;
        mem[key(1, 1)] = 4'b0001;
        run_tb("del31", 3, 1, "DDM", 3, 0, 0);

        mem.delete();
        mem[key(3, 5)] = 4'b0001;
        mem[key(2, 4)] = 4'b0001;
        mem[key(1, 3)] = 4'b0001;
        run_tb("diag_edge35", 3, 5, "MMMII", 3, 0, 0);

        mem.delete();
        run_tb("row0", 0, 5, "IIIII", 0, 0, 0);
        run_tb("col0", 4, 0, "DDDD", 0, 0, 0);

        mem[key(2, 4)] = 4'b0011;
        mem[key(2, 3)] = 4'b0100;
        mem[key(2, 2)] = 4'b0001;
        mem[key(1, 1)] = 4'b0001;
        ready_mode = 1;
        run_tb("toggle24", 2, 4, "IIMM", 4, 1, 0);
        ready_mode = 0;

        mem.delete();
        mem[key(3, 2)] = 4'b0000;
        mem[key(1, 1)] = 4'b0001;
        run_tb("vstart32", 3, 2, "", 1, 0, 1);
        run_tb("origin", 0, 0, "", 0, 0, 0);

        mem.delete();
        mem[key(3, 3)] = 4'b0001;
        mem[key(2, 2)] = 4'b0001;
        mem[key(1, 1)] = 4'b0001;
        ready_mode = 2;
        @(posedge clk); #1;
        i_row   = 10'd3;
        i_col   = 10'd3;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 0;
        while (!o_op_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midrun_emit_reached", o_op_valid, 1);
        dc0 = done_count;
        #2 rst = 1'b1;
        #1 check_idle_outs("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_done", done_count - dc0, 0);
        check_idle_outs("rst_after");
        run_tb("post_rst33", 3, 3, "MMM", 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
